ty_axis_fork_out: RTL and testbench

//  Output-side bridge between the TyBEC-generated "main" pipeline and the SDx AXI-stream masters.

---
 rtl/ty_axis_fork_out_if.sv | 37 +++
 rtl/ty_axis_fork_out.sv | 82 ++++++++
 tb/tb_ty_axis_fork_out.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ty_axis_fork_out_if.sv
// ty_axis_fork_out_if
//  Bundles the single ovalid/oready handshake coming out of main together with
//  the per-channel AXI-stream master signals that leave the fork.
//  Handshake semantics (both sides): a word moves on a rising clock edge when
//  valid and ready are both 1 at that edge. Valid never waits on ready. Once
//  valid is raised, it and its data are held until the transfer happens.
//  Signals
//   ovalid   main -> fork   words on all channels valid together
//   odata    main -> fork   one word per channel
//   oready   fork -> main   1 = every channel can accept a word
//   m_tvalid fork -> sink   per-channel valid
//   m_tdata  fork -> sink   per-channel data
//   m_tready sink -> fork   per-channel ready
//  Modports
//   slave  : the fork itself (accepts from main, drives the stream masters)
//   master : the environment (main plus the sinks)
interface ty_axis_fork_out_if #(
  parameter int C_DATA_WIDTH   = 512,
  parameter int C_NUM_CHANNELS = 2
);
  logic                                         ovalid;
  logic [C_NUM_CHANNELS-1:0][C_DATA_WIDTH-1:0]  odata;
  logic                                         oready;
  logic [C_NUM_CHANNELS-1:0]                    m_tvalid;
  logic [C_NUM_CHANNELS-1:0][C_DATA_WIDTH-1:0]  m_tdata;
  logic [C_NUM_CHANNELS-1:0]                    m_tready;

  modport slave (
    input  ovalid, odata, m_tready,
    output oready, m_tvalid, m_tdata
  );

  modport master (
    output ovalid, odata, m_tready,
    input  oready, m_tvalid, m_tdata
  );
endinterface

// File: rtl/ty_axis_fork_out.sv
// ty_axis_fork_out
//  Forks main's single output handshake into C_NUM_CHANNELS independent
//  AXI-stream masters. Each channel owns a FIFO_DEPTH-word FIFO so a stalled
//  sink only stalls main once its own FIFO fills; the other channels keep
//  draining. A word from main is accepted on all channels at once or not at all.
//  Ports
//   aclk    clock, rising edge
//   areset  asynchronous, active-high reset
//   axis    ty_axis_fork_out_if.slave: ovalid/odata/oready from main,
//           m_tvalid/m_tdata/m_tready per channel toward the sinks
module ty_axis_fork_out #(
  parameter int C_DATA_WIDTH   = 512,
  parameter int C_NUM_CHANNELS = 2,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                   aclk,
  input  logic                   areset,
  ty_axis_fork_out_if.slave      axis
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [C_DATA_WIDTH-1:0] mem    [C_NUM_CHANNELS][FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr [C_NUM_CHANNELS];
  logic [PW-1:0]           rd_ptr [C_NUM_CHANNELS];
  logic [CW-1:0]           count  [C_NUM_CHANNELS];

  logic [C_NUM_CHANNELS-1:0] full;
  logic [C_NUM_CHANNELS-1:0] pop;
  logic                      push;

  // Output side is a pure function of registered state, so m_tvalid and
  // oready never depend combinationally on m_tready. A full channel blocks
  // main even if it pops this cycle (no full pass-through).
  always_comb begin
    full          = '0;
    pop           = '0;
    axis.m_tvalid = '0;
    axis.m_tdata  = '0;
    for (int c = 0; c < C_NUM_CHANNELS; c++) begin
      full[c]          = (count[c] == DEPTH_C);
      axis.m_tvalid[c] = (count[c] != '0);
      axis.m_tdata[c]  = mem[c][rd_ptr[c]];
      pop[c]           = axis.m_tvalid[c] & axis.m_tready[c];
    end
  end

  assign axis.oready = ~areset & ~(|full);
  assign push        = axis.ovalid & axis.oready;

  // Storage is deliberately not reset; stale words are masked by count == 0.
  always_ff @(posedge aclk) begin
    if (push) begin
      for (int c = 0; c < C_NUM_CHANNELS; c++) begin
        mem[c][wr_ptr[c]] <= axis.odata[c];
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int c = 0; c < C_NUM_CHANNELS; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < C_NUM_CHANNELS; c++) begin
        if (push)   wr_ptr[c] <= wr_ptr[c] + PW'(1);
        if (pop[c]) rd_ptr[c] <= rd_ptr[c] + PW'(1);
        case ({push, pop[c]})
          2'b10:   count[c] <= count[c] + CW'(1);
          2'b01:   count[c] <= count[c] - CW'(1);
          default: count[c] <= count[c];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ty_axis_fork_out.sv
module tb_ty_axis_fork_out;

  localparam int W     = 64;
  localparam int NC    = 2;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic areset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ty_axis_fork_out_if #(.C_DATA_WIDTH(W), .C_NUM_CHANNELS(NC)) bus ();

  ty_axis_fork_out #(
    .C_DATA_WIDTH(W),
    .C_NUM_CHANNELS(NC),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .aclk(clk),
    .areset(areset),
    .axis(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // One queue of expected words per channel. The sink sees the queue head;
  // main may push only when every queue has room.
  logic [W-1:0] exp_q [NC][$];
  bit           m_push;
  bit [NC-1:0]  m_pop;

  function automatic bit model_ready();
    bit r;
    r = !areset;
    for (int c = 0; c < NC; c++) if (exp_q[c].size() >= DEPTH) r = 0;
    return r;
  endfunction

  always @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int c = 0; c < NC; c++) exp_q[c].delete();
    end else begin
      m_push = bus.ovalid && model_ready();
      for (int c = 0; c < NC; c++) m_pop[c] = (exp_q[c].size() != 0) && bus.m_tready[c];
      for (int c = 0; c < NC; c++) begin
        if (m_push)   exp_q[c].push_back(bus.odata[c]);
        if (m_pop[c]) void'(exp_q[c].pop_front());
      end
    end
  end

  // ---------------- scoreboard compare, away from the active edge ----------------
  always @(negedge clk) begin
    check("oready", W'(bus.oready), W'(model_ready()));
    for (int c = 0; c < NC; c++) begin
      check($sformatf("m_tvalid[%0d]", c), W'(bus.m_tvalid[c]), W'(exp_q[c].size() != 0));
      if (exp_q[c].size() != 0)
        check($sformatf("m_tdata[%0d]", c), bus.m_tdata[c], exp_q[c][0]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] word(input int c, input int i);
    return (W'(c) << 32) | W'(i);
  endfunction

  task automatic set_word(input int i);
    for (int c = 0; c < NC; c++) bus.odata[c] = word(c, i);
  endtask

  bit accepted;

  initial begin
    areset       = 1'b1;
    bus.ovalid   = 1'b0;
    bus.odata    = '0;
    bus.m_tready = '0;
    repeat (3) step();
    check("reset_oready", W'(bus.oready), W'(0));
    check("reset_tvalid", W'(bus.m_tvalid), W'(0));
    areset = 1'b0;
    step();
    check("post_reset_oready", W'(bus.oready), W'(1));

    // T1: reset with 3 words queued
    bus.m_tready = '0;
    for (int i = 1; i <= 3; i++) begin
      bus.ovalid = 1'b1;
      set_word(i);
      step();
    end
    bus.ovalid = 1'b0;
    check("t1_queued_tvalid", W'(bus.m_tvalid), W'(2'b11));
    areset = 1'b1;
    #1;
    check("t1_async_tvalid", W'(bus.m_tvalid), W'(0));
    check("t1_async_oready", W'(bus.oready), W'(0));
    step();
    areset = 1'b0;
    step();
    check("t1_release_oready", W'(bus.oready), W'(1));
    check("t1_release_tvalid", W'(bus.m_tvalid), W'(0));

    // T2: streaming, all sinks ready
    bus.m_tready = 2'b11;
    for (int i = 1; i <= 16; i++) begin
      bus.ovalid = 1'b1;
      set_word(i);
      step();
      if (i == 1) check("t2_first_ch0", bus.m_tdata[0], W'(64'h1));
      if (i == 16) check("t2_last_ch1", bus.m_tdata[1], W'(64'h1_0000_0010));
    end
    bus.ovalid = 1'b0;
    step();
    check("t2_drained", W'(bus.m_tvalid), W'(0));

    // T3: ch1 stalled, push 6 -> 4 accepted
    bus.m_tready = 2'b01;
    begin
      int nxt = 1;
      for (int k = 0; k < 6; k++) begin
        bus.ovalid = 1'b1;
        set_word(nxt);
        accepted = bus.oready;
        step();
        if (accepted) nxt++;
      end
      check("t3_accepted", W'(nxt - 1), W'(4));
    end
    check("t3_oready", W'(bus.oready), W'(0));
    check("t3_tvalid", W'(bus.m_tvalid), W'(2'b10));
    check("t3_ch1_head", bus.m_tdata[1], W'(64'h1_0000_0001));

    // T4: ch1 full pops while main offers word 5
    bus.m_tready = 2'b11;
    check("t4_full_pop_oready", W'(bus.oready), W'(0));
    step();
    bus.m_tready = 2'b01;
    check("t4_next_oready", W'(bus.oready), W'(1));
    step();
    bus.ovalid = 1'b0;
    check("t4_ch1_head", bus.m_tdata[1], W'(64'h1_0000_0002));
    check("t4_full_again", W'(bus.oready), W'(0));
    bus.m_tready = 2'b11;
    repeat (6) step();

    // T6: ch0 at count 2, push and pop together
    bus.m_tready = 2'b00;
    for (int i = 32'h20; i <= 32'h21; i++) begin
      bus.ovalid = 1'b1;
      set_word(i);
      step();
    end
    bus.ovalid = 1'b1;
    set_word(32'h22);
    bus.m_tready = 2'b01;
    check("t6_head_before", bus.m_tdata[0], W'(64'h20));
    step();
    bus.ovalid = 1'b0;
    check("t6_head_after", bus.m_tdata[0], W'(64'h21));
    step();
    check("t6_third", bus.m_tdata[0], W'(64'h22));
    step();
    check("t6_empty_after_two", W'(bus.m_tvalid[0]), W'(0));
    bus.m_tready = 2'b11;
    repeat (4) step();

    // T5: random traffic; main holds a word until it is accepted
    accepted = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!bus.ovalid || accepted) begin
        bus.ovalid = ($urandom_range(0, 3) != 0);
        for (int c = 0; c < NC; c++) bus.odata[c] = {$urandom, $urandom};
      end
      bus.m_tready = NC'($urandom_range(0, (1 << NC) - 1));
      accepted = bus.ovalid && bus.oready;
      step();
    end
    bus.ovalid   = 1'b0;
    bus.m_tready = 2'b11;
    repeat (DEPTH + 2) step();
    check("t5_drained", W'(bus.m_tvalid), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
